twiddle_seq_r4: RTL and testbench

- Sequencer for the 256-point radix-4 twiddle ROM, which has an 8-bit address, 18-bit data and one clock of registered read latency.
- On a start pulse it walks stage -> butterfly -> leg and drives the ROM address.
- It emits a valid/ready-qualified tag stream that is cycle-aligned with the ROM data, so the butterfly multiplier consumes twiddle and tags together.
- Downstream back-pressure is absorbed by holding the ROM address; the ROM itself has no enable.

---
 rtl/twiddle_pkg.sv | 40 ++++
 rtl/twiddle_seq_r4_if.sv | 26 ++
 rtl/twiddle_idx_r4.sv | 13 +
 rtl/twiddle_seq_r4.sv | 104 ++++++++++
 tb/tb_twiddle_seq_r4.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/twiddle_pkg.sv
// Shared definitions for the radix-4 twiddle sequencers: sizes, FSM encoding,
// tag layout and the (stage, butterfly) -> twiddle index mapping.
package twiddle_pkg;

  localparam int FFT_N      = 256;
  localparam int STAGES     = 4;
  localparam int BFLY       = 64;
  localparam int LEGS       = 4;
  localparam int ADDRLENGTH = 8;
  localparam int WORDLENGTH = 18;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] stage;
    logic [5:0] bfly;
    logic [1:0] leg;
  } tag_t;

  // (b mod 4^(3-s)) << 2s, kept to 6 bits: later stages keep fewer low
  // butterfly bits and shift them further up, so stage 3 is always unity.
  function automatic logic [5:0] tw_idx_f(input logic [1:0] stage,
                                          input logic [5:0] bfly);
    logic [5:0] idx;
    idx = '0;
    case (stage)
      2'd0:    idx = bfly;
      2'd1:    idx = {bfly[3:0], 2'b00};
      2'd2:    idx = {bfly[1:0], 4'b0000};
      default: idx = '0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/twiddle_seq_r4_if.sv
// Handshake and tag bundle between the twiddle sequencer (master) and the
// butterfly datapath / controller (slave).
interface twiddle_seq_r4_if;
  import twiddle_pkg::*;

  logic                  start;
  logic                  out_ready;
  logic [ADDRLENGTH-1:0] rom_addr;
  logic                  tw_valid;
  logic [1:0]            tw_stage;
  logic [5:0]            tw_bfly;
  logic [1:0]            tw_leg;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, out_ready,
    output rom_addr, tw_valid, tw_stage, tw_bfly, tw_leg, busy, done
  );

  modport slave (
    output start, out_ready,
    input  rom_addr, tw_valid, tw_stage, tw_bfly, tw_leg, busy, done
  );

endinterface

// File: rtl/twiddle_idx_r4.sv
// Combinational radix-4 twiddle index: (stage, butterfly) -> tw_idx[5:0].
// Shared with the inverse-FFT sequencer.
module twiddle_idx_r4
  import twiddle_pkg::*;
(
  input  logic [1:0] stage,
  input  logic [5:0] bfly,
  output logic [5:0] tw_idx
);

  assign tw_idx = tw_idx_f(stage, bfly);

endmodule

// File: rtl/twiddle_seq_r4.sv
// Walks stage -> butterfly -> leg over the 256-point radix-4 twiddle ROM and
// emits a valid/ready tag stream aligned with the ROM's registered read data.
module twiddle_seq_r4
  import twiddle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  twiddle_seq_r4_if.master  tw
);

  state_t                state_q, state_d;
  logic [1:0]            s_q;
  logic [5:0]            b_q;
  logic [1:0]            l_q;
  logic [ADDRLENGTH-1:0] addr_last_q;
  logic [ADDRLENGTH-1:0] cnt_addr;
  tag_t                  tag_q;
  logic                  valid_q;
  logic [5:0]            tw_idx;
  logic                  issue;
  logic                  last_elem;
  logic                  busy;
  logic                  done;

  twiddle_idx_r4 u_idx (
    .stage  (s_q),
    .bfly   (b_q),
    .tw_idx (tw_idx)
  );

  assign cnt_addr  = {tw_idx, l_q};
  assign last_elem = (s_q == 2'(STAGES - 1)) && (b_q == 6'(BFLY - 1)) &&
                     (l_q == 2'(LEGS - 1));

  // A new element is issued whenever the output slot is empty or being
  // accepted this cycle; otherwise the ROM keeps re-reading the last address.
  assign issue = (state_q == RUN) && (!valid_q || tw.out_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tw.start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (issue && last_elem) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (valid_q && tw.out_ready) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, held address, tags and valid. Counters wrap back to zero after
  // the final element, so a finished sweep leaves them ready for the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      b_q         <= '0;
      l_q         <= '0;
      addr_last_q <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
    end else if (issue) begin
      addr_last_q <= cnt_addr;
      tag_q       <= '{stage: s_q, bfly: b_q, leg: l_q};
      valid_q     <= 1'b1;
      l_q         <= l_q + 2'd1;
      if (l_q == 2'(LEGS - 1)) begin
        b_q <= b_q + 6'd1;
        if (b_q == 6'(BFLY - 1)) s_q <= s_q + 2'd1;
      end
    end else if (valid_q && tw.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign tw.rom_addr = issue ? cnt_addr : addr_last_q;
  assign tw.tw_valid = valid_q;
  assign tw.tw_stage = tag_q.stage;
  assign tw.tw_bfly  = tag_q.bfly;
  assign tw.tw_leg   = tag_q.leg;
  assign tw.busy     = busy;
  assign tw.done     = done;

endmodule

// File: tb/tb_twiddle_seq_r4.sv
// Directed bench for twiddle_seq_r4 with a one-cycle registered ROM model.
module tb_twiddle_seq_r4;
  import twiddle_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  twiddle_seq_r4_if tw ();

  twiddle_seq_r4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tw    (tw)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] UNITY = 18'b011111111000000000;

  // ROM contents: unity for index 0, otherwise the address itself on top so
  // the data word identifies which address was read.
  function automatic logic [17:0] rom_word(input logic [7:0] a);
    if (a[7:2] == 6'd0) return UNITY;
    return {a, 10'h155};
  endfunction

  logic [17:0] rom_q;
  always @(posedge clk) rom_q <= rom_word(tw.rom_addr);

  logic [9:0]  cur_tag;
  logic [20:0] all_outs;
  assign cur_tag  = {tw.tw_stage, tw.tw_bfly, tw.tw_leg};
  assign all_outs = {tw.rom_addr, tw.tw_valid, cur_tag, tw.busy, tw.done};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [9:0]  gold_tag  [1024];
  logic [7:0]  gold_addr [1024];
  logic [7:0]  addr_log  [1024];
  logic [9:0]  tag_log   [1024];
  logic [17:0] data_log  [1024];

  int sw_beats, sw_bad, sw_dones, sw_vcyc, sw_bcyc, sw_last_acc, sw_done_cyc;

  // One full sweep from a start pulse. mode 0: ready held high; mode 1:
  // random ready. stall_at >= 0 holds ready low for 5 cycles on that beat.
  task automatic sweep(input int mode, input int stall_at, input bit poke,
                       input bit log_en);
    int         stall_left;
    bit         stalled, prev_hold, fin;
    logic [9:0] prev_tag;
    logic [17:0] prev_data;
    sw_beats = 0; sw_bad = 0; sw_dones = 0; sw_vcyc = 0; sw_bcyc = 0;
    sw_last_acc = -1; sw_done_cyc = -1;
    stall_left = 0; stalled = 0; prev_hold = 0; fin = 0;
    prev_tag = '0; prev_data = '0;
    @(negedge clk);
    tw.start = 1'b1;
    tw.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      @(negedge clk);
      tw.start = poke && (cyc == 100 || tw.done);
      if (stall_at >= 0 && !stalled && tw.tw_valid && sw_beats == stall_at) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0)  tw.out_ready = 1'b0;
      else if (mode == 1)  tw.out_ready = ($urandom_range(0, 1) == 1);
      else                 tw.out_ready = 1'b1;
      #1;
      if (stall_left > 0) begin
        check("stall_hold", {tw.tw_valid, cur_tag, rom_q, tw.rom_addr},
              {1'b1, gold_tag[stall_at], rom_word(gold_addr[stall_at]),
               gold_addr[stall_at]});
        stall_left--;
      end
      if (log_en && cyc < 1024) addr_log[cyc] = tw.rom_addr;
      if (tw.busy) sw_bcyc++;
      if (tw.tw_valid) sw_vcyc++;
      if (prev_hold && (!tw.tw_valid || cur_tag != prev_tag || rom_q != prev_data))
        sw_bad++;
      if (tw.done) begin
        sw_dones++;
        sw_done_cyc = cyc;
      end
      if (tw.tw_valid && tw.out_ready) begin
        if (sw_beats < 1024) begin
          if (cur_tag !== gold_tag[sw_beats] ||
              rom_q !== rom_word(gold_addr[sw_beats])) begin
            if (sw_bad == 0)
              $display("first diff at beat %0d: tag %0h data %0h", sw_beats,
                       cur_tag, rom_q);
            sw_bad++;
          end
          if (log_en) begin
            tag_log[sw_beats]  = cur_tag;
            data_log[sw_beats] = rom_q;
          end
        end else begin
          sw_bad++;
        end
        sw_beats++;
        sw_last_acc = cyc;
      end
      prev_hold = tw.tw_valid && !tw.out_ready;
      prev_tag  = cur_tag;
      prev_data = rom_q;
      if (sw_dones > 0 && !tw.done) fin = 1'b1;
    end
    tw.start = 1'b0;
    check("sweep_finished", 64'(fin), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("idle_after_sweep", {tw.busy, tw.tw_valid, tw.done}, 3'b000);
  endtask

  typedef struct {
    logic [1:0] s;
    logic [5:0] b;
    logic [1:0] l;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int k, idx, cnt;
    bit found;

    for (int s = 0; s < 4; s++)
      for (int b = 0; b < 64; b++)
        for (int l = 0; l < 4; l++) begin
          k   = s * 256 + b * 4 + l;
          idx = ((b % (1 << (2 * (3 - s)))) << (2 * s)) & 63;
          gold_tag[k]  = {2'(s), 6'(b), 2'(l)};
          gold_addr[k] = 8'(idx * 4 + l);
        end

    vecs[0]  = '{2'd0, 6'd0,  2'd0, 8'd0};
    vecs[1]  = '{2'd0, 6'd0,  2'd3, 8'd3};
    vecs[2]  = '{2'd0, 6'd1,  2'd0, 8'd4};
    vecs[3]  = '{2'd0, 6'd1,  2'd3, 8'd7};
    vecs[4]  = '{2'd0, 6'd9,  2'd2, 8'd38};
    vecs[5]  = '{2'd0, 6'd63, 2'd3, 8'd255};
    vecs[6]  = '{2'd1, 6'd5,  2'd0, 8'd80};
    vecs[7]  = '{2'd1, 6'd5,  2'd3, 8'd83};
    vecs[8]  = '{2'd1, 6'd63, 2'd0, 8'd240};
    vecs[9]  = '{2'd2, 6'd7,  2'd0, 8'd192};
    vecs[10] = '{2'd2, 6'd7,  2'd3, 8'd195};
    vecs[11] = '{2'd2, 6'd63, 2'd2, 8'd194};
    vecs[12] = '{2'd3, 6'd0,  2'd0, 8'd0};
    vecs[13] = '{2'd3, 6'd63, 2'd3, 8'd3};

    tw.start     = 1'b0;
    tw.out_ready = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", 64'(all_outs), 64'd0);
    rst_n = 1'b1;

    // Full sweep with ready held high
    sweep(0, -1, 1'b0, 1'b1);
    check("t1_beats", 64'(sw_beats), 64'd1024);
    check("t1_beat_errors", 64'(sw_bad), 64'd0);
    check("t1_valid_cycles", 64'(sw_vcyc), 64'd1024);
    check("t1_busy_cycles", 64'(sw_bcyc), 64'd1025);
    check("t1_done_count", 64'(sw_dones), 64'd1);
    check("t1_done_latency", 64'(sw_done_cyc - sw_last_acc), 64'd1);

    foreach (vecs[i]) begin
      k = int'(vecs[i].s) * 256 + int'(vecs[i].b) * 4 + int'(vecs[i].l);
      check($sformatf("vec%0d_addr", i), 64'(addr_log[k]), 64'(vecs[i].addr));
      check($sformatf("vec%0d_tag", i), 64'(tag_log[k]),
            64'({vecs[i].s, vecs[i].b, vecs[i].l}));
      check($sformatf("vec%0d_data", i), 64'(data_log[k]),
            64'(rom_word(vecs[i].addr)));
    end

    cnt = 0;
    for (int j = 768; j < 1024; j++)
      if (addr_log[j] > 8'd3 || data_log[j] != UNITY) cnt++;
    check("stage3_unity", 64'(cnt), 64'd0);

    // Five-cycle stall on s=0, b=9, l=2
    sweep(0, 38, 1'b0, 1'b0);
    check("t3_beats", 64'(sw_beats), 64'd1024);
    check("t3_beat_errors", 64'(sw_bad), 64'd0);
    check("t3_done_count", 64'(sw_dones), 64'd1);

    // Random back-pressure
    sweep(1, -1, 1'b0, 1'b0);
    check("t4_beats", 64'(sw_beats), 64'd1024);
    check("t4_beat_errors", 64'(sw_bad), 64'd0);
    check("t4_done_count", 64'(sw_dones), 64'd1);

    // Spurious start during RUN and DONE
    sweep(0, -1, 1'b1, 1'b0);
    check("t6_beats", 64'(sw_beats), 64'd1024);
    check("t6_beat_errors", 64'(sw_bad), 64'd0);
    check("t6_done_count", 64'(sw_dones), 64'd1);

    // Asynchronous reset in the middle of stage 1
    found = 1'b0;
    @(negedge clk);
    tw.start     = 1'b1;
    tw.out_ready = 1'b1;
    @(negedge clk);
    tw.start = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      #1;
      if (tw.tw_valid && cur_tag == {2'd1, 6'd30, 2'd0}) found = 1'b1;
      else @(negedge clk);
    end
    check("t5_reached_s1_b30", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", 64'(all_outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0, -1, 1'b0, 1'b1);
    check("t5_restart_first_addr", 64'(addr_log[0]), 64'd0);
    check("t5_restart_first_tag", 64'(tag_log[0]), 64'd0);
    check("t5_beats", 64'(sw_beats), 64'd1024);
    check("t5_beat_errors", 64'(sw_bad), 64'd0);
    check("t5_done_count", 64'(sw_dones), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
